// File: rtl/clint_timer.sv
// CLINT-style machine interrupt source: 64-bit mtime/mtimecmp, msip bit and ext IRQ synchroniser on a Wishbone-classic slave.
// Optional build macro CLINT_PRESCALER_EN adds a PRESCALE register at 0x18 that divides the mtime tick.
module clint_timer #(
    parameter int ADDR_W = 8,
    parameter int SYNC_N = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [ADDR_W-1:0] wbs_addr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    input  logic              ext_irq_i,
    output logic              xint_mtip_o,
    output logic              xint_msip_o,
    output logic              xint_meip_o
);

    logic [63:0]       mtime;
    logic [63:0]       mtimecmp;
    logic [SYNC_N-1:0] sync_q;
    logic              req;
    logic              wr;
    logic              tick;
    logic              mapped;
    logic              hit_msip;
    logic              hit_cmp_lo;
    logic              hit_cmp_hi;
    logic              hit_mt_lo;
    logic              hit_mt_hi;
    logic              hit_psc;
    logic [31:0]       rdata;
    logic              unused_addr;
`ifdef CLINT_PRESCALER_EN
    logic [15:0]       prescale;
    logic [15:0]       psc_cnt;
    logic [15:0]       psc_wdata;
`endif

    assign unused_addr = ^wbs_addr_i[1:0];

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++) begin
            r[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        hit_msip   = 1'b0;
        hit_cmp_lo = 1'b0;
        hit_cmp_hi = 1'b0;
        hit_mt_lo  = 1'b0;
        hit_mt_hi  = 1'b0;
        hit_psc    = 1'b0;
        if (~|wbs_addr_i[ADDR_W-1:5]) begin
            case (wbs_addr_i[4:2])
                3'd0: hit_msip   = 1'b1;
                3'd2: hit_cmp_lo = 1'b1;
                3'd3: hit_cmp_hi = 1'b1;
                3'd4: hit_mt_lo  = 1'b1;
                3'd5: hit_mt_hi  = 1'b1;
`ifdef CLINT_PRESCALER_EN
                3'd6: hit_psc    = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign mapped = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_mt_lo | hit_mt_hi | hit_psc;
    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    assign wr     = req & wbs_we_i;

    always_comb begin
        rdata = '0;
        if (hit_msip)   rdata[0] = xint_msip_o;
        if (hit_cmp_lo) rdata    = mtimecmp[31:0];
        if (hit_cmp_hi) rdata    = mtimecmp[63:32];
        if (hit_mt_lo)  rdata    = mtime[31:0];
        if (hit_mt_hi)  rdata    = mtime[63:32];
`ifdef CLINT_PRESCALER_EN
        if (hit_psc)    rdata[15:0] = prescale;
`endif
    end

    // Response and write commit share the request edge, so a reset in the request cycle drops both.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req & mapped;
            wbs_err_o <= req & ~mapped;
            wbs_dat_o <= (req & mapped & ~wbs_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xint_msip_o <= 1'b0;
        end else if (wr & hit_msip & wbs_sel_i[0]) begin
            xint_msip_o <= wbs_dat_i[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtimecmp <= '1;
        end else begin
            if (wr & hit_cmp_lo) mtimecmp[31:0]  <= lane_merge(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
            if (wr & hit_cmp_hi) mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
        end
    end

    // A half-write replaces that half only and suppresses the tick for the cycle (no carry either way).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime <= '0;
        end else if (wr & hit_mt_lo) begin
            mtime[31:0] <= lane_merge(mtime[31:0], wbs_dat_i, wbs_sel_i);
        end else if (wr & hit_mt_hi) begin
            mtime[63:32] <= lane_merge(mtime[63:32], wbs_dat_i, wbs_sel_i);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xint_mtip_o <= 1'b0;
        end else begin
            xint_mtip_o <= (mtime >= mtimecmp);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], ext_irq_i};
        end
    end

    assign xint_meip_o = sync_q[SYNC_N-1];

`ifdef CLINT_PRESCALER_EN
    assign psc_wdata = {wbs_sel_i[1] ? wbs_dat_i[15:8] : prescale[15:8],
                        wbs_sel_i[0] ? wbs_dat_i[7:0]  : prescale[7:0]};

    assign tick = (psc_cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prescale <= '0;
            psc_cnt  <= '0;
        end else if (wr & hit_psc) begin
            prescale <= psc_wdata;
            psc_cnt  <= psc_wdata;
        end else if (tick) begin
            psc_cnt <= prescale;
        end else begin
            psc_cnt <= psc_cnt - 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

endmodule
